// File: rtl/rx.sv
// rx: one-bit-per-clock UART receiver, start/data/parity/stop framing.
// Define UART_RX_SYNC_EN to add a two-flop input synchronizer.
`timescale 1ns/1ps
module rx #(
  parameter int WIDTH    = 8,
  parameter int stop_bit = 2,
  parameter int test     = 2
) (
  input  logic             rx_clk,
  input  logic             rx_rst_n,
  input  logic             rx_data_in,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_done,
  output logic             rx_parity_err,
  output logic             rx_frame_err,
  output logic             rx_busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    bit_cnt_q;
  logic [1:0]       stop_cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic             par_acc_q;
  logic             frm_acc_q;
  logic             din;
  logic             par_bad;
  logic             last_stop;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  // Reset to 1 so the line reads idle while reset releases.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_data_in};
    end
  end

  assign din = sync_q[1];
`else
  assign din = rx_data_in;
`endif

  assign par_bad = ((test == 1) && (din != ~^shift_q)) ||
                   ((test == 2) && (din != ^shift_q));

  assign last_stop = (stop_cnt_q == 2'(stop_bit - 1));

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      stop_cnt_q    <= '0;
      shift_q       <= '0;
      par_acc_q     <= 1'b0;
      frm_acc_q     <= 1'b0;
      rx_data       <= '0;
      rx_done       <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      rx_done       <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!din) begin
            state_q    <= DATA;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            par_acc_q  <= 1'b0;
            frm_acc_q  <= 1'b0;
            rx_busy    <= 1'b1;
          end
        end
        DATA: begin
          shift_q[bit_cnt_q] <= din;
          bit_cnt_q          <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == CW'(WIDTH - 1)) begin
            state_q    <= (test != 0) ? PARITY : STOP;
            stop_cnt_q <= '0;
          end
        end
        PARITY: begin
          if (par_bad) begin
            par_acc_q <= 1'b1;
          end
          state_q <= STOP;
        end
        STOP: begin
          if (!din) begin
            frm_acc_q <= 1'b1;
          end
          stop_cnt_q <= stop_cnt_q + 1'b1;
          // Errors never abort: the word is delivered with its flags.
          if (last_stop) begin
            state_q       <= IDLE;
            rx_data       <= shift_q;
            rx_done       <= 1'b1;
            rx_parity_err <= par_acc_q;
            rx_frame_err  <= frm_acc_q | ~din;
            rx_busy       <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
